// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack sequencing controller.
package rpn_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned FLAG_W = 4;

   // Bit positions inside the status bus: {error, busy, full}
   localparam int unsigned STATUS_W    = 3;
   localparam int unsigned STATUS_FULL = 0;
   localparam int unsigned STATUS_BUSY = 1;
   localparam int unsigned STATUS_ERR  = 2;

endpackage : rpn_pkg

// File: rtl/rpn_stack_ctrl_if.sv
// Bus bundle between the RPN controller and its surroundings
// (debouncer, switches, ALU, display selector, LEDs).
interface rpn_stack_ctrl_if
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned DW = $clog2(DEPTH + 1);

   logic                enter_pulse;
   logic                clear_pulse;
   logic                is_op;
   logic [WIDTH-1:0]    data_in;
   logic [WIDTH-1:0]    alu_a;
   logic [WIDTH-1:0]    alu_b;
   logic [OP_W-1:0]     alu_op;
   logic [WIDTH-1:0]    alu_result;
   logic [FLAG_W-1:0]   alu_flags;
   logic [WIDTH-1:0]    to_display;
   logic [FLAG_W-1:0]   flags;
   logic [DW-1:0]       depth;
   logic                busy;
   logic [STATUS_W-1:0] status;

   // Environment side: user inputs and the combinational ALU
   modport master (
      output enter_pulse, clear_pulse, is_op, data_in, alu_result, alu_flags,
      input  alu_a, alu_b, alu_op, to_display, flags, depth, busy, status
   );

   // Controller side
   modport slave (
      input  enter_pulse, clear_pulse, is_op, data_in, alu_result, alu_flags,
      output alu_a, alu_b, alu_op, to_display, flags, depth, busy, status
   );

endinterface : rpn_stack_ctrl_if

// File: rtl/rpn_stack.sv
// Operand stack: DEPTH x WIDTH register file with a depth counter,
// push / replace-top-two-with-one / clear commands and top, top-1 read ports.
module rpn_stack #(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             reduce,
   input  logic [WIDTH-1:0] reduce_data,
   input  logic             clear,
   output logic [DW-1:0]    depth,
   output logic [WIDTH-1:0] top_c,
   output logic [WIDTH-1:0] next_c
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    next_idx;

   // Slot addresses relative to the current depth; only used when in range
   always_comb begin
      push_idx = AW'(depth_q);
      top_idx  = AW'(depth_q - DW'(1));
      next_idx = AW'(depth_q - DW'(2));
   end

   // Storage and depth counter; clear only drops the count
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         depth_q <= '0;
      end else if (clear) begin
         depth_q <= '0;
      end else if (push) begin
         mem_q[push_idx] <= push_data;
         depth_q         <= depth_q + DW'(1);
      end else if (reduce) begin
         mem_q[next_idx] <= reduce_data;
         depth_q         <= depth_q - DW'(1);
      end
   end

   // Read ports read as zero when the entry is not valid
   always_comb begin
      top_c  = (depth_q != '0)      ? mem_q[top_idx]  : '0;
      next_c = (depth_q >= DW'(2))  ? mem_q[next_idx] : '0;
   end

   assign depth = depth_q;

endmodule : rpn_stack

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish sequencing controller: pushes operands, issues the top two
// entries to the external ALU and folds the result back onto the stack.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              resetN,
   rpn_stack_ctrl_if.slave   bus
);

   localparam int unsigned DW = $clog2(DEPTH + 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  alu_a_q, alu_a_d;
   logic [WIDTH-1:0]  alu_b_q, alu_b_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              error_q, error_d;

   logic              stk_push;
   logic              stk_reduce;
   logic              stk_clear;
   logic [DW-1:0]     stk_depth;
   logic [WIDTH-1:0]  stk_top_c;
   logic [WIDTH-1:0]  stk_next_c;
   logic              full_c;
   logic [STATUS_W-1:0] status_c;

   rpn_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk         (clk),
      .resetN      (resetN),
      .push        (stk_push),
      .push_data   (bus.data_in),
      .reduce      (stk_reduce),
      .reduce_data (bus.alu_result),
      .clear       (stk_clear),
      .depth       (stk_depth),
      .top_c       (stk_top_c),
      .next_c      (stk_next_c)
   );

   assign full_c = (stk_depth == DW'(DEPTH));

   // State, ALU operand and flag registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         flags_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         flags_q  <= flags_d;
         error_q  <= error_d;
      end
   end

   // Next-state and stack command decode; clear outranks enter
   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      flags_d    = flags_q;
      error_d    = error_q;
      stk_push   = 1'b0;
      stk_reduce = 1'b0;
      stk_clear  = 1'b0;

      if (bus.clear_pulse) begin
         state_d   = IDLE;
         flags_d   = '0;
         error_d   = 1'b0;
         stk_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.enter_pulse) begin
                  if (!bus.is_op) begin
                     if (full_c) begin
                        state_d = ERR;
                        error_d = 1'b1;
                     end else begin
                        stk_push = 1'b1;
                     end
                  end else if (stk_depth >= DW'(2)) begin
                     alu_a_d  = stk_next_c;
                     alu_b_d  = stk_top_c;
                     alu_op_d = bus.data_in[OP_W-1:0];
                     state_d  = EXEC;
                  end else begin
                     state_d = ERR;
                     error_d = 1'b1;
                  end
               end
            end
            // Single-cycle result write-back; enter pulses here are dropped
            EXEC: begin
               stk_reduce = 1'b1;
               flags_d    = bus.alu_flags;
               state_d    = IDLE;
            end
            // Any enter acknowledges the error without pushing
            ERR: begin
               if (bus.enter_pulse) begin
                  state_d = IDLE;
                  error_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Status bus decode
   always_comb begin
      status_c              = '0;
      status_c[STATUS_ERR]  = error_q;
      status_c[STATUS_BUSY] = (state_q == EXEC);
      status_c[STATUS_FULL] = full_c;
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.flags      = flags_q;
   assign bus.to_display = stk_top_c;
   assign bus.depth      = stk_depth;
   assign bus.busy       = (state_q == EXEC);
   assign bus.status     = status_c;

endmodule : rpn_stack_ctrl

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Sequencing controller for the calculator datapath. Replaces the fixed A/B/OpCode load sequence with a reverse-Polish operand stack that is DEPTH entries deep.
- Sits between the debouncer (consumes its single-cycle Enter pulse) and the combinational ALU (drives A, B and OpCode; captures Result and Status).
- Feeds the display selector with top-of-stack, and the board LEDs with flags and status.

Parameters:
- WIDTH, 16, operand/result width.
- DEPTH, 4, stack entries (>=2).
- DW, $clog2(DEPTH+1), width of the depth count (derived localparam, not overridable).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- enter_pulse  in  1  debounced one-cycle Enter pulse
- clear_pulse  in  1  one-cycle synchronous clear request
- is_op  in  1  0: data_in is an operand; 1: data_in[1:0] is an opcode
- data_in  in  WIDTH  switch value
- alu_a  out  WIDTH  ALU operand A (registered)
- alu_b  out  WIDTH  ALU operand B (registered)
- alu_op  out  2  ALU opcode (registered)
- alu_result  in  WIDTH  ALU combinational result
- alu_flags  in  4  ALU combinational status flags
- to_display  out  WIDTH  top of stack, 0 when empty
- flags  out  4  flags of last completed operation
- depth  out  DW  number of valid stack entries
- busy  out  1  high while in EXEC
- status  out  3  {error, state==EXEC, depth==DEPTH}

Behaviour:
- Reset (resetN=0, async): state IDLE, depth 0, all stack entries 0, alu_a/alu_b/alu_op 0, flags 0, error 0. Therefore to_display=0, busy=0, status=3'b000.
- States: IDLE, EXEC, ERR. Encoding comes from the package enum.
- Priority each cycle: clear_pulse > enter_pulse.
- clear_pulse (any state): next edge gives IDLE, depth 0, flags 0, error 0. Stack contents need not be zeroed, but to_display must read 0.
- IDLE, enter_pulse, is_op=0:
  - depth<DEPTH: stack[depth]<=data_in, depth+1. Single cycle; to_display shows the new value the cycle after the edge.
  - depth==DEPTH (overflow): stack and depth unchanged, go to ERR.
- IDLE, enter_pulse, is_op=1:
  - depth>=2: alu_a<=stack[depth-2] (older entry), alu_b<=stack[depth-1], alu_op<=data_in[1:0], go to EXEC.
  - depth<2 (underflow): stack unchanged, go to ERR.
- EXEC (exactly one cycle, busy=1):
  - stack[depth-2]<=alu_result, flags<=alu_flags, depth-1, go to IDLE.
  - enter_pulse arriving in EXEC is dropped: no queueing, no error.
- Latency: operator Enter edge at cycle N gives the result on to_display and flags from cycle N+2.
- ERR: error=1; stack, depth and to_display are preserved. An enter_pulse (either is_op value) acknowledges: go to IDLE with error 0, and the value is NOT pushed.
- alu_a/alu_b/alu_op hold their last values outside EXEC.
- No arithmetic inside the block. The result is stored as-is, WIDTH bits, no extension.
- resetN asserted mid-EXEC: outputs return to their reset values immediately, with no partial write.
- Every output is a register or a pure decode of registers; there is no combinational path from any input to any output.

Decomposition:
- Package rpn_pkg holds:
  - state_t enum {IDLE, EXEC, ERR}.
  - STATUS_* bit-index constants.
- Sub-module rpn_stack holds the storage: DEPTH x WIDTH register file with a depth counter and three commands, push, replace-top-two-with-one, and clear. It provides read ports top and top-1.
- rpn_stack_ctrl holds the FSM, the ALU operand/flag registers and the error flag.

Test Plan:
- Push/add: push 5, push 7, op 2'b00 (bench ALU model ADD) -> depth goes 1, 2, 1; busy high for exactly 1 cycle; to_display 12 two cycles after the op Enter; flags = model flags for 5+7.
- Operand order: push 9, push 4, op SUB -> alu_a=9, alu_b=4, to_display=5, depth=1.
- Overflow: push 1, 2, 3, 4 then push 5 -> status=3'b101, depth 4, to_display 4; next Enter -> error 0, depth still 4.
- Underflow: push 3, op -> ERR, depth 1, to_display 3, alu_a/alu_b unchanged; Enter acknowledges -> IDLE.
- Enter during EXEC: op Enter followed by push Enter on the next cycle -> second pulse ignored, depth = pre-op depth-1.
- Clear and reset: clear_pulse coincident with enter_pulse at depth 3 -> depth 0, to_display 0, no push; resetN low during EXEC -> all outputs 0 asynchronously, and the stack is still empty after release.
